// File: rtl/control_pulse_register_bank.sv
// Host control register with masked writes; the low NUM_CH bits are not stored.
// Instead, each of those bits drives its own self-timed step-pulse channel with busy and sticky overrun status.
module control_pulse_register_bank #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter int                PULSE_W   = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iWriteEnable,
  input  logic [DATA_W-1:0] iValue,
  input  logic [DATA_W-1:0] iMask,
  input  logic [NUM_CH-1:0] iOverrunClear,
  output logic [DATA_W-1:0] oControlRegister,
  output logic [NUM_CH-1:0] oPulse,
  output logic [NUM_CH-1:0] oBusy,
  output logic [NUM_CH-1:0] oOverrun
);

  localparam logic [1:0]        ST_IDLE      = 2'd0;
  localparam logic [1:0]        ST_PULSE     = 2'd1;
  localparam logic [1:0]        ST_HOLD      = 2'd2;
  localparam logic [7:0]        LAST_CNT     = 8'(PULSE_W - 1);
  localparam logic [DATA_W-1:0] PERSIST_MASK = {{(DATA_W - NUM_CH){1'b1}}, {NUM_CH{1'b0}}};

  logic [NUM_CH-1:0][1:0] r_state;
  logic [NUM_CH-1:0][7:0] r_cnt;
  logic [DATA_W-1:0]      r_ctrl;
  logic [NUM_CH-1:0]      r_pulse;
  logic [NUM_CH-1:0]      r_busy;
  logic [NUM_CH-1:0]      r_overrun;

  logic [NUM_CH-1:0]      w_req;
  logic [NUM_CH-1:0][1:0] w_state_nxt;
  logic [NUM_CH-1:0][7:0] w_cnt_nxt;
  logic [NUM_CH-1:0]      w_overrun_nxt;

  // A pulse request is level-sensitive and exists only during a write strobe.
  assign w_req = {NUM_CH{iWriteEnable}} & iMask[NUM_CH-1:0] & iValue[NUM_CH-1:0];

  // Per-channel next state; HOLD absorbs a held request so one level gives one pulse.
  always_comb begin
    w_state_nxt   = '0;
    w_cnt_nxt     = '0;
    w_overrun_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (r_state[i])
        ST_IDLE: begin
          if (w_req[i]) begin
            w_state_nxt[i] = ST_PULSE;
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
          w_cnt_nxt[i] = 8'd0;
        end
        ST_PULSE: begin
          if (r_cnt[i] == LAST_CNT) begin
            w_state_nxt[i] = ST_HOLD;
            w_cnt_nxt[i]   = 8'd0;
          end else begin
            w_state_nxt[i] = ST_PULSE;
            w_cnt_nxt[i]   = r_cnt[i] + 8'd1;
          end
        end
        ST_HOLD: begin
          if (w_req[i]) begin
            w_state_nxt[i] = ST_HOLD;
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
          w_cnt_nxt[i] = 8'd0;
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = 8'd0;
        end
      endcase
      // Setting beats clearing when both happen in the same cycle.
      if ((r_state[i] == ST_PULSE) && w_req[i]) begin
        w_overrun_nxt[i] = 1'b1;
      end else if (iOverrunClear[i]) begin
        w_overrun_nxt[i] = 1'b0;
      end else begin
        w_overrun_nxt[i] = r_overrun[i];
      end
    end
  end

  // Channel state and registered status outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state   <= '0;
      r_cnt     <= '0;
      r_pulse   <= '0;
      r_busy    <= '0;
      r_overrun <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pulse[i] <= (w_state_nxt[i] == ST_PULSE);
        r_busy[i]  <= (w_state_nxt[i] != ST_IDLE);
      end
    end
  end

  // Persistent bits: masked write; channel bit positions are held at zero.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_ctrl <= RESET_VAL & PERSIST_MASK;
    end else if (iWriteEnable) begin
      r_ctrl <= ((r_ctrl & ~iMask) | (iValue & iMask)) & PERSIST_MASK;
    end else begin
      r_ctrl <= r_ctrl;
    end
  end

  assign oControlRegister = r_ctrl;
  assign oPulse           = r_pulse;
  assign oBusy            = r_busy;
  assign oOverrun         = r_overrun;

endmodule

// File: tb/tb_control_pulse_register_bank.sv
// Directed and random checks of control_pulse_register_bank against a
// time-based reference model of the register and pulse channels.
module tb_control_pulse_register_bank;
  localparam int          DW = 32;
  localparam int          NC = 4;
  localparam int          PW = 3;
  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic          iClock = 1'b0;
  logic          iReset;
  logic          iWriteEnable;
  logic [DW-1:0] iValue;
  logic [DW-1:0] iMask;
  logic [NC-1:0] iOverrunClear;
  logic [DW-1:0] oControlRegister;
  logic [NC-1:0] oPulse;
  logic [NC-1:0] oBusy;
  logic [NC-1:0] oOverrun;

  always #5 iClock = ~iClock;

  control_pulse_register_bank #(
    .DATA_W(DW), .NUM_CH(NC), .PULSE_W(PW), .RESET_VAL(RV)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iWriteEnable(iWriteEnable),
    .iValue(iValue), .iMask(iMask), .iOverrunClear(iOverrunClear),
    .oControlRegister(oControlRegister), .oPulse(oPulse),
    .oBusy(oBusy), .oOverrun(oOverrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  // Reference model: a channel is active from the edge that started it;
  // it pulses for the next PW cycles, then lingers until the request is gone.
  logic [31:0] m_reg;
  bit          m_active [NC];
  int          m_start  [NC];
  logic [NC-1:0] m_ovr, m_pulse, m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc_n, obs, exp);
  endtask

  task automatic model_edge(input logic rst, input logic we, input logic [31:0] val,
                            input logic [31:0] mask, input logic [NC-1:0] clr);
    bit req, in_pulse;
    if (rst) begin
      m_reg = RV;
      for (int i = 0; i < NC; i++) m_active[i] = 1'b0;
      m_ovr = '0; m_pulse = '0; m_busy = '0;
    end else begin
      for (int b = NC; b < DW; b++)
        if (we && mask[b]) m_reg[b] = val[b];
      for (int i = 0; i < NC; i++) begin
        req      = we & mask[i] & val[i];
        in_pulse = m_active[i] && (cyc_n <= m_start[i] + PW);
        if (in_pulse && req) m_ovr[i] = 1'b1;
        else if (clr[i])     m_ovr[i] = 1'b0;
        if (!m_active[i]) begin
          if (req) begin
            m_active[i] = 1'b1;
            m_start[i]  = cyc_n;
          end
        end else if (!in_pulse && !req) begin
          m_active[i] = 1'b0;
        end
        m_pulse[i] = m_active[i] && (cyc_n <= m_start[i] + PW - 1);
        m_busy[i]  = m_active[i];
      end
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic [31:0] val,
                      input logic [31:0] mask, input logic [NC-1:0] clr);
    iReset = rst; iWriteEnable = we; iValue = val; iMask = mask; iOverrunClear = clr;
    @(posedge iClock);
    model_edge(rst, we, val, mask, clr);
    cyc_n++;
    #1;
    chk("reg",     oControlRegister, m_reg);
    chk("pulse",   {28'd0, oPulse},   {28'd0, m_pulse});
    chk("busy",    {28'd0, oBusy},    {28'd0, m_busy});
    chk("overrun", {28'd0, oOverrun}, {28'd0, m_ovr});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    int          hi_cnt;
    int          busy_cnt;
    int          rise_cnt;
    logic        prev_p;
    logic        r_rst;
    logic        r_we;
    logic [31:0] r_val;
    logic [31:0] r_mask;
    logic [3:0]  r_clr;

    // Test 1: reset values and a reset that aborts a pulse in flight.
    step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("rst_reg", oControlRegister, 32'hA5A5_0000);
    chk("rst_out", {20'd0, oPulse, oBusy, oOverrun}, 32'd0);
    step(1'b0, 1'b1, 32'd1, 32'd1, 4'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("mid_pulse", {28'd0, oPulse}, 32'd1);
    step(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("abort_pulse", {28'd0, oPulse}, 32'd0);
    chk("abort_busy",  {28'd0, oBusy},  32'd0);

    // Test 2: masked persistent writes.
    step(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 4'd0);
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_FF00, 4'd0);
    chk("mask_wr1", oControlRegister, 32'h0000_FF00);
    step(1'b0, 1'b1, 32'd0, 32'h0000_0F00, 4'd0);
    chk("mask_wr2", oControlRegister, 32'h0000_F000);
    idle(2);

    // Test 3: single-cycle request gives a PW-cycle pulse and PW+1 busy cycles.
    hi_cnt = 0; busy_cnt = 0;
    step(1'b0, 1'b1, 32'd1, 32'd1, 4'd0);
    if (oPulse[0]) hi_cnt++;
    if (oBusy[0])  busy_cnt++;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      if (oPulse[0]) hi_cnt++;
      if (oBusy[0])  busy_cnt++;
    end
    chk("pulse_width", hi_cnt, PW);
    chk("busy_width",  busy_cnt, PW + 1);

    // Test 4: a held request yields exactly one pulse; re-trigger after a gap.
    rise_cnt = 0; prev_p = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 32'd2, 32'd2, 4'd0);
      if (oPulse[1] && !prev_p) rise_cnt++;
      prev_p = oPulse[1];
    end
    chk("held_one_pulse", rise_cnt, 1);
    chk("held_busy", {31'd0, oBusy[1]}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010);
    chk("held_release", {31'd0, oBusy[1]}, 32'd0);
    step(1'b0, 1'b1, 32'd2, 32'd2, 4'd0);
    chk("retrigger", {31'd0, oPulse[1]}, 32'd1);
    idle(5);

    // Test 5: overrun set, pulse not extended, clear, and set-beats-clear.
    hi_cnt = 0;
    step(1'b0, 1'b1, 32'd4, 32'd4, 4'd0);
    if (oPulse[2]) hi_cnt++;
    idle(1);
    if (oPulse[2]) hi_cnt++;
    step(1'b0, 1'b1, 32'd4, 32'd4, 4'd0);
    if (oPulse[2]) hi_cnt++;
    chk("ovr_set", {31'd0, oOverrun[2]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      if (oPulse[2]) hi_cnt++;
    end
    chk("ovr_pulse_width", hi_cnt, PW);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0100);
    chk("ovr_clear", {31'd0, oOverrun[2]}, 32'd0);
    step(1'b0, 1'b1, 32'd4, 32'd4, 4'd0);
    step(1'b0, 1'b1, 32'd4, 32'd4, 4'b0100);
    chk("ovr_set_wins", {31'd0, oOverrun[2]}, 32'd1);
    idle(5);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b1111);

    // Test 6: mixed persistent/pulse write starts all channels together.
    step(1'b0, 1'b1, 32'h0001_000F, 32'h0001_000F, 4'd0);
    chk("all_pulse", {28'd0, oPulse}, 32'h0000_000F);
    chk("bit16", {31'd0, oControlRegister[16]}, 32'd1);
    chk("low_zero", {28'd0, oControlRegister[3:0]}, 32'd0);
    idle(5);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      r_rst  = ($urandom_range(0, 49) == 0);
      r_we   = ($urandom_range(0, 2) != 0);
      r_val  = $urandom;
      r_mask = $urandom;
      r_clr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      step(r_rst, r_we, r_val, r_mask, r_clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
